// File: rtl/block_data_memory_if.sv
// block_data_memory_if: cache-to-memory block read/write bus between the cache miss FSM (master) and backing memory (slave)
interface block_data_memory_if #(
  parameter int addr_w = 28,
  parameter int data_w = 128
);
  logic              m_read_i;
  logic              m_wr_i;
  logic [addr_w-1:0] m_address_i;
  logic [data_w-1:0] m_write_data_i;
  logic [data_w-1:0] m_read_data_o;
  logic              m_busywait_o;
  logic              m_read_done_o;
  logic              m_write_done_o;
  modport master (
    output m_read_i, m_wr_i, m_address_i, m_write_data_i,
    input  m_read_data_o, m_busywait_o, m_read_done_o, m_write_done_o
  );
  modport slave (
    input  m_read_i, m_wr_i, m_address_i, m_write_data_i,
    output m_read_data_o, m_busywait_o, m_read_done_o, m_write_done_o
  );
endinterface

// File: rtl/block_data_memory.sv
// block_data_memory: fixed-latency block-granular backing memory; optional access counters under DMEM_ACCESS_CNT_EN
module block_data_memory #(
  parameter int c_line_size    = 32,
  parameter int c_block_size   = 2,
  parameter int address_size   = 32,
  parameter int mem_depth_log2 = 10,
  parameter int mem_latency    = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  block_data_memory_if.slave    m
`ifdef DMEM_ACCESS_CNT_EN
  ,
  output logic [31:0]           rd_count_o,
  output logic [31:0]           wr_count_o
`endif
);
  localparam int blk_w      = (2 ** c_block_size) * c_line_size;
  localparam int blk_addr_w = address_size - c_block_size - 2;
  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, DONE} state_t;
  state_t                    state_q, state_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [mem_depth_log2-1:0] addr_q, addr_d;
  logic [blk_w-1:0]          wdata_q, wdata_d;
  logic [blk_w-1:0]          rdata_q, rdata_d;
  logic                      busy_q, busy_d;
  logic                      rdone_q, rdone_d;
  logic                      wdone_q, wdone_d;
  logic                      mem_we;
  logic                      unused_addr;
  logic [blk_w-1:0]          mem [0:(2**mem_depth_log2)-1];
  assign unused_addr = ^m.m_address_i[blk_addr_w-1:mem_depth_log2];
  // Next-state, capture of request, and commit/fetch on the last busy cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (m.m_wr_i) begin
          state_d = WRITE_WAIT;
          addr_d  = m.m_address_i[mem_depth_log2-1:0];
          wdata_d = m.m_write_data_i;
          cnt_d   = 8'(mem_latency - 1);
        end else if (m.m_read_i) begin
          state_d = READ_WAIT;
          addr_d  = m.m_address_i[mem_depth_log2-1:0];
          cnt_d   = 8'(mem_latency - 1);
        end
      end
      READ_WAIT: begin
        cnt_d = (cnt_q == 8'd0) ? 8'd0 : cnt_q - 8'd1;
        if (cnt_q == 8'd0) begin
          state_d = DONE;
          rdata_d = mem[addr_q];
        end
      end
      WRITE_WAIT: begin
        cnt_d  = (cnt_q == 8'd0) ? 8'd0 : cnt_q - 8'd1;
        mem_we = (cnt_q == 8'd0);
        state_d = (cnt_q == 8'd0) ? DONE : WRITE_WAIT;
      end
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d == READ_WAIT) || (state_d == WRITE_WAIT);
    rdone_d = (state_q == READ_WAIT) && (state_d == DONE);
    wdone_d = (state_q == WRITE_WAIT) && (state_d == DONE);
  end
  // State and registered outputs; reset abandons any access in flight
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      rdone_q <= 1'b0;
      wdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      rdone_q <= rdone_d;
      wdone_q <= wdone_d;
    end
  end
  // Array is not cleared by reset; a write colliding with reset is dropped
  always_ff @(posedge clk_i) begin
    if (mem_we && !reset_i) mem[addr_q] <= wdata_q;
  end
  assign m.m_read_data_o  = rdata_q;
  assign m.m_busywait_o   = busy_q;
  assign m.m_read_done_o  = rdone_q;
  assign m.m_write_done_o = wdone_q;
`ifdef DMEM_ACCESS_CNT_EN
  logic [31:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  always_comb begin
    rd_cnt_d = rd_cnt_q + 32'(rdone_d);
    wr_cnt_d = wr_cnt_q + 32'(wdone_d);
  end
  // Counters advance together with their done pulse and wrap naturally
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_cnt_q <= 32'd0;
      wr_cnt_q <= 32'd0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end
  assign rd_count_o = rd_cnt_q;
  assign wr_count_o = wr_cnt_q;
`endif
endmodule
